// File: rtl/bitu_exu.sv
// Execute-stage shell for the GRP bit-manipulation unit: two-stage pipeline with valid/ready on both sides.
// Optional popcount (op CNT) is built only when BITU_EXU_CNT_EN is defined; otherwise CNT reports as illegal.
module bitu_exu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned TAGW = 5;

    typedef enum logic [1:0] {
        OP_GRP  = 2'b00,
        OP_GRPN = 2'b01,
        OP_CNT  = 2'b10,
        OP_RSV  = 2'b11
    } op_e;

    // Pack bits of x selected by m towards the LSB end, preserving order.
    function automatic logic [XLEN-1:0] compress(input logic [XLEN-1:0] x, input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        logic [5:0]      k;
        r = '0;
        k = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (m[i]) begin
                r[k[4:0]] = x[i];
                k         = k + 6'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mirror(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = x[XLEN-1-i];
        end
        return r;
    endfunction

`ifdef BITU_EXU_CNT_EN
    function automatic logic [5:0] popcnt(input logic [XLEN-1:0] x);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < XLEN; i++) begin
            c = c + 6'(x[i]);
        end
        return c;
    endfunction
`endif

    logic            s1_valid;
    op_e             s1_op;
    logic [XLEN-1:0] s1_mask;
    logic [XLEN-1:0] s1_data;
    logic [TAGW-1:0] s1_rd;
    logic            s2_valid;

    logic            s1_load;
    logic            s2_load;
    logic [XLEN-1:0] s1_and;
    logic [XLEN-1:0] s1_mir;
    logic [XLEN-1:0] grp_lo;
    logic [XLEN-1:0] grp_hi;
    logic [XLEN-1:0] s1_result;
    logic            s1_err;

    // Pipeline advance: S2 refills when empty or draining, S1 when it empties into S2.
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !flush && (!s1_valid || s2_load);
    assign s1_load  = in_valid && in_ready;

    // Selected bits compress to the LSB end; the unselected group is compressed in the
    // mirrored domain so it lands at the MSB end with its order preserved.
    assign s1_and = s1_data & s1_mask;
    assign s1_mir = mirror(s1_data & ~s1_mask);
    assign grp_lo = compress(s1_and, s1_mask);
    assign grp_hi = mirror(compress(s1_mir, mirror(~s1_mask)));

    always_comb begin
        s1_result = '0;
        s1_err    = 1'b0;
        case (s1_op)
            OP_GRP, OP_GRPN: s1_result = grp_lo | grp_hi;
`ifdef BITU_EXU_CNT_EN
            OP_CNT:          s1_result = XLEN'(popcnt(s1_mask));
`endif
            default:         s1_err    = 1'b1;
        endcase
    end

    // Valid bits: flush kills everything in flight at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= s1_load || (s1_valid && !s2_load);
            s2_valid <= s2_load || (s2_valid && !out_ready);
        end
    end

    // S1 payload: GRPN is folded into an inverted mask at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op   <= OP_GRP;
            s1_mask <= '0;
            s1_data <= '0;
            s1_rd   <= '0;
        end else if (s1_load) begin
            s1_op   <= op_e'(in_op);
            s1_mask <= (op_e'(in_op) == OP_GRPN) ? ~in_rs2 : in_rs2;
            s1_data <= in_rs1;
            s1_rd   <= in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_rd   <= '0;
            out_err  <= 1'b0;
        end else if (s2_load && !flush) begin
            out_data <= s1_result;
            out_rd   <= s1_rd;
            out_err  <= s1_err;
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_bitu_exu.sv
// Self-checking bench for bitu_exu: queue-based reference model checked every cycle plus directed scenarios.
module tb_bitu_exu;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_err;

    bitu_exu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    logic [4:0]  dlv[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          acc_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result {err, data} from the operation definitions.
    function automatic logic [32:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        logic [31:0] r;
        bit          sel[$];
        bit          rest[$];
        int          ns;
        m = b;
        r = '0;
        case (op)
            2'b00: m = b;
            2'b01: m = ~b;
            2'b10: begin
`ifdef BITU_EXU_CNT_EN
                return {1'b0, 32'($countones(b))};
`else
                return {1'b1, 32'h0};
`endif
            end
            default: return {1'b1, 32'h0};
        endcase
        for (int i = 0; i < 32; i++) begin
            if (m[i]) sel.push_back(a[i]);
            else      rest.push_back(a[i]);
        end
        ns = sel.size();
        for (int j = 0; j < 32; j++) r[j] = (j < ns) ? sel[j] : rest[j-ns];
        return {1'b0, r};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge rst_n) q.delete();

    // Per-cycle compare against the in-flight queue; an op is visible two edges after presentation.
    always @(negedge clk) begin
        bit          exp_ready;
        bit          exp_ov;
        logic [32:0] rr;
        exp_t        e;
        if (rst_n) begin
            exp_ready = !flush && (q.size() < 2 || out_ready);
            exp_ov    = (q.size() > 0) && (cyc >= q[0].cyc + 2);
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            if (exp_ov) begin
                check("out_data", 64'(out_data), 64'(q[0].d));
                check("out_rd", 64'(out_rd), 64'(q[0].rd));
                check("out_err", 64'(out_err), 64'(q[0].err));
                if (out_ready) begin
                    dlv.push_back(out_rd);
                    void'(q.pop_front());
                end
            end
            if (flush) begin
                q.delete();
            end else if (in_valid && exp_ready) begin
                rr    = ref_result(in_op, in_rs1, in_rs2);
                e.d   = rr[31:0];
                e.err = rr[32];
                e.rd  = in_rd;
                e.cyc = cyc;
                q.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic pin(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_err, input logic [31:0] exp_d);
        check(name, 64'(ref_result(op, a, b)), 64'({exp_err, exp_d}));
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        out_ready = 1'b1;

        #3;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_rd", 64'(out_rd), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        pin("pin_grp", 2'b00, 32'h8000_0001, 32'hF000_0000, 1'b0, 32'h0000_0018);
        pin("pin_grpn", 2'b01, 32'h8000_0001, 32'h0FFF_FFFF, 1'b0, 32'h0000_0018);
`ifdef BITU_EXU_CNT_EN
        pin("pin_cnt", 2'b10, 32'h1234_5678, 32'hFF00_FF00, 1'b0, 32'd16);
`else
        pin("pin_cnt", 2'b10, 32'h1234_5678, 32'hFF00_FF00, 1'b1, 32'd0);
`endif
        pin("pin_rsv", 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'd0);
        pin("pin_swap", 2'b00, 32'h1234_ABCD, 32'hFFFF_0000, 1'b0, 32'hABCD_1234);
        pin("pin_ident", 2'b00, 32'h1234_ABCD, 32'h0000_FFFF, 1'b0, 32'h1234_ABCD);

        // Basic GRP with a direct literal look at the output.
        send(2'b00, 32'h8000_0001, 32'hF000_0000, 5'd3);
        @(posedge clk);
        #1;
        check("basic_valid", 64'(out_valid), 64'(1));
        check("basic_data", 64'(out_data), 64'h18);
        check("basic_rd", 64'(out_rd), 64'd3);
        idle(3);

        // Full-rate stream of mixed ops.
        send(2'b01, 32'h8000_0001, 32'h0FFF_FFFF, 5'd4);
        send(2'b10, 32'h1234_5678, 32'hFF00_FF00, 5'd5);
        send(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd6);
        send(2'b00, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd7);
        send(2'b00, 32'hDEAD_BEEF, 32'h0000_0000, 5'd8);
        send(2'b00, 32'h1234_ABCD, 32'hFFFF_0000, 5'd9);
        send(2'b01, 32'hC3A5_5A3C, 32'h9696_0F0F, 5'd31);
        idle(4);

        // Backpressure: only two ops fit while the output is stalled.
        base = acc_cnt;
        dlv.delete();
        out_ready = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                check("bp_accepted", 64'(acc_cnt - base), 64'd2);
                #1 out_ready = 1'b1;
            end
            begin
                for (int i = 1; i <= 4; i++) send(2'b00, 32'hA5A5_0000 | 32'(i), 32'h0F0F_00FF, 5'(i));
            end
        join
        idle(4);
        check("bp_count", 64'(dlv.size()), 64'd4);
        for (int i = 0; i < 4 && i < dlv.size(); i++) check("bp_order", 64'(dlv[i]), 64'(i + 1));

        // Flush with two in flight; the result handshaken during flush is delivered.
        dlv.delete();
        out_ready = 1'b0;
        send(2'b00, 32'h0000_F00F, 32'h00FF_00FF, 5'd17);
        send(2'b01, 32'h0000_F00F, 32'h00FF_00FF, 5'd18);
        base      = acc_cnt;
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_rs1    = 32'h1111_1111;
        in_rs2    = 32'h0000_000F;
        in_rd     = 5'd19;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_no_valid", 64'(out_valid), 64'(0));
        end
        check("flush_not_accepted", 64'(acc_cnt - base), 64'd0);
        @(posedge clk);
        #1;
        send(2'b00, 32'h8000_0001, 32'hF000_0000, 5'd20);
        idle(4);
        check("flush_dlv_count", 64'(dlv.size()), 64'd2);
        if (dlv.size() == 2) begin
            check("flush_dlv_first", 64'(dlv[0]), 64'd17);
            check("flush_dlv_next", 64'(dlv[1]), 64'd20);
        end

        // Asynchronous reset while a result is waiting.
        out_ready = 1'b0;
        send(2'b01, 32'hCAFE_F00D, 32'h00FF_00FF, 5'd11);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_pre_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_data", 64'(out_data), 64'(0));
        check("mid_rst_rd", 64'(out_rd), 64'(0));
        check("mid_rst_err", 64'(out_err), 64'(0));
        #5 rst_n = 1'b1;
        #1 check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(2'b00, 32'h1234_ABCD, 32'h0000_FFFF, 5'd12);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
